// File: rtl/lock_ctrl_if.sv
// Keypad-lock bus: key strobes and timeout in, state and display data out.
interface lock_ctrl_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        timeout;
  logic [1:0]  state;
  logic        unlock;
  logic        alarm;
  logic [15:0] entry;
  logic [2:0]  digit_cnt;
  logic [1:0]  err_cnt;

  modport master (
    output key_valid, key_code, timeout,
    input  state, unlock, alarm, entry, digit_cnt, err_cnt
  );

  modport slave (
    input  key_valid, key_code, timeout,
    output state, unlock, alarm, entry, digit_cnt, err_cnt
  );
endinterface

// File: rtl/lock_ctrl.sv
// Keypad lock sequencer: collects BCD digits, checks them against the stored
// password, counts failures into ALARM and leaves ALARM on the delay timer's timeout.
module lock_ctrl #(
  parameter int          DIGITS      = 4,
  parameter int          MAX_TRIES   = 3,
  parameter logic [15:0] DEFAULT_PWD = 16'h1234
) (
  input  logic       clk,
  input  logic       rst_n,
  lock_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_INPUT = 2'b01,
    S_OPEN  = 2'b10,
    S_ALARM = 2'b11
  } state_e;

  localparam logic [3:0]  K_CONFIRM = 4'hA;
  localparam logic [3:0]  K_CLEAR   = 4'hB;
  localparam logic [3:0]  K_SETPWD  = 4'hC;
  localparam logic [2:0]  DIG_N     = 3'(DIGITS);
  localparam logic [2:0]  TRIES_N   = 3'(MAX_TRIES);
  localparam logic [15:0] MASK      = 16'((32'h1 << (4 * DIGITS)) - 32'h1);

  state_e      state_q, state_d;
  logic [15:0] entry_q, entry_d;
  logic [2:0]  digit_cnt_q, digit_cnt_d;
  logic [1:0]  err_cnt_q, err_cnt_d;
  logic [15:0] pwd_q, pwd_d;
  logic        set_mode_q, set_mode_d;
  logic [2:0]  to_sync_q;

  logic        to_pulse;
  logic        is_digit;
  logic        full;
  logic        match;
  logic        last_try;
  logic [15:0] entry_shift;

  // Two sync flops plus one history flop; the pulse is seen 2 edges after the rise
  // and acted on at the 3rd.
  assign to_pulse    = to_sync_q[1] & ~to_sync_q[2];
  assign is_digit    = (bus.key_code <= 4'd9);
  assign full        = (digit_cnt_q == DIG_N);
  assign match       = ((entry_q & MASK) == (pwd_q & MASK));
  assign last_try    = (({1'b0, err_cnt_q} + 3'd1) == TRIES_N);
  assign entry_shift = {entry_q[11:0], bus.key_code} & MASK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      entry_q     <= '0;
      digit_cnt_q <= '0;
      err_cnt_q   <= '0;
      pwd_q       <= DEFAULT_PWD & MASK;
      set_mode_q  <= 1'b0;
      to_sync_q   <= '0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      digit_cnt_q <= digit_cnt_d;
      err_cnt_q   <= err_cnt_d;
      pwd_q       <= pwd_d;
      set_mode_q  <= set_mode_d;
      to_sync_q   <= {to_sync_q[1:0], bus.timeout};
    end
  end

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    digit_cnt_d = digit_cnt_q;
    err_cnt_d   = err_cnt_q;
    pwd_d       = pwd_q;
    set_mode_d  = set_mode_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.key_valid && is_digit) begin
          state_d     = S_INPUT;
          entry_d     = {12'h000, bus.key_code} & MASK;
          digit_cnt_d = 3'd1;
        end
      end
      S_INPUT: begin
        if (bus.key_valid) begin
          if (is_digit) begin
            if (!full) begin
              entry_d     = entry_shift;
              digit_cnt_d = digit_cnt_q + 3'd1;
            end
          end else if (bus.key_code == K_CLEAR) begin
            entry_d     = '0;
            digit_cnt_d = '0;
            state_d     = S_IDLE;
          end else if (bus.key_code == K_CONFIRM) begin
            entry_d     = '0;
            digit_cnt_d = '0;
            if (full && match) begin
              state_d   = S_OPEN;
              err_cnt_d = '0;
            end else if (last_try) begin
              state_d   = S_ALARM;
              err_cnt_d = '0;
            end else begin
              state_d   = S_IDLE;
              err_cnt_d = err_cnt_q + 2'd1;
            end
          end
        end
      end
      S_OPEN: begin
        if (bus.key_valid) begin
          if (is_digit) begin
            if (!full) begin
              entry_d     = entry_shift;
              digit_cnt_d = digit_cnt_q + 3'd1;
            end
          end else if (bus.key_code == K_SETPWD) begin
            set_mode_d  = 1'b1;
            entry_d     = '0;
            digit_cnt_d = '0;
          end else if (bus.key_code == K_CONFIRM && set_mode_q) begin
            // A short entry keeps set_mode so the user can simply retype.
            if (full) begin
              pwd_d      = entry_q & MASK;
              set_mode_d = 1'b0;
            end
            entry_d     = '0;
            digit_cnt_d = '0;
          end else if (bus.key_code == K_CLEAR) begin
            set_mode_d  = 1'b0;
            entry_d     = '0;
            digit_cnt_d = '0;
            state_d     = S_IDLE;
          end
        end
      end
      S_ALARM: begin
        if (to_pulse) begin
          state_d     = S_IDLE;
          entry_d     = '0;
          digit_cnt_d = '0;
          err_cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.state     = state_q;
    bus.unlock    = (state_q == S_OPEN);
    bus.alarm     = (state_q == S_ALARM);
    bus.entry     = entry_q;
    bus.digit_cnt = digit_cnt_q;
    bus.err_cnt   = err_cnt_q;
  end

endmodule

// File: tb/tb_lock_ctrl.sv
// Directed bench for lock_ctrl: hand-computed expectations for each key sequence.
module tb_lock_ctrl;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  lock_ctrl_if bus();

  lock_ctrl #(.DIGITS(4), .MAX_TRIES(3), .DEFAULT_PWD(16'h1234)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic press(input logic [3:0] k);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_code  = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.key_code  = 4'hF;
  endtask

  task automatic try_code(input logic [15:0] c);
    press(c[15:12]);
    press(c[11:8]);
    press(c[7:4]);
    press(c[3:0]);
    press(4'hA);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'hF;
    bus.timeout   = 1'b0;
    repeat (2) @(negedge clk);

    // 1: reset values, then the default code opens
    chk("rst_state", bus.state, 2'b00);
    chk("rst_unlock", bus.unlock, 1'b0);
    chk("rst_alarm", bus.alarm, 1'b0);
    chk("rst_entry", bus.entry, 16'h0);
    chk("rst_dcnt", bus.digit_cnt, 3'd0);
    chk("rst_err", bus.err_cnt, 2'd0);
    rst_n = 1'b1;
    press(4'h1);
    chk("t1_state_input", bus.state, 2'b01);
    chk("t1_entry1", bus.entry, 16'h0001);
    press(4'h2); press(4'h3); press(4'h4);
    chk("t1_entry4", bus.entry, 16'h1234);
    chk("t1_dcnt4", bus.digit_cnt, 3'd4);
    press(4'hA);
    chk("t1_state_open", bus.state, 2'b10);
    chk("t1_unlock", bus.unlock, 1'b1);
    chk("t1_err", bus.err_cnt, 2'd0);
    chk("t1_entry_clr", bus.entry, 16'h0);
    press(4'hB);
    chk("t1_relock", bus.state, 2'b00);

    // 2: three wrong attempts, alarm, timeout release
    try_code(16'h1235);
    chk("t2_err1", bus.err_cnt, 2'd1);
    chk("t2_idle1", bus.state, 2'b00);
    try_code(16'h1235);
    chk("t2_err2", bus.err_cnt, 2'd2);
    try_code(16'h1235);
    chk("t2_alarm_state", bus.state, 2'b11);
    chk("t2_alarm", bus.alarm, 1'b1);
    chk("t2_err0", bus.err_cnt, 2'd0);
    press(4'h1); press(4'hB);
    chk("t2_keys_ign_st", bus.state, 2'b11);
    chk("t2_keys_ign_en", bus.entry, 16'h0);
    @(negedge clk);
    bus.timeout = 1'b1;
    @(posedge clk); #1;
    chk("t2_to_edge1", bus.state, 2'b11);
    @(posedge clk); #1;
    chk("t2_to_edge2", bus.state, 2'b11);
    @(posedge clk); #1;
    chk("t2_to_edge3", bus.state, 2'b00);
    chk("t2_to_alarm", bus.alarm, 1'b0);
    repeat (5) @(negedge clk);
    bus.timeout = 1'b0;
    repeat (4) @(negedge clk);

    // 3: change password to 9876
    try_code(16'h1234);
    chk("t3_open", bus.state, 2'b10);
    press(4'hC);
    press(4'h9); press(4'h8); press(4'h7); press(4'h6);
    chk("t3_set_entry", bus.entry, 16'h9876);
    press(4'hA);
    chk("t3_stay_open", bus.state, 2'b10);
    press(4'hB);
    chk("t3_relock", bus.state, 2'b00);
    try_code(16'h9876);
    chk("t3_new_pwd", bus.state, 2'b10);
    press(4'hB);
    try_code(16'h1234);
    chk("t3_old_pwd_err", bus.err_cnt, 2'd1);
    chk("t3_old_pwd_st", bus.state, 2'b00);

    // 6: async reset in INPUT restores defaults
    press(4'h1); press(4'h2);
    chk("t6_dcnt2", bus.digit_cnt, 3'd2);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_state", bus.state, 2'b00);
    chk("t6_entry", bus.entry, 16'h0);
    chk("t6_dcnt", bus.digit_cnt, 3'd0);
    chk("t6_err", bus.err_cnt, 2'd0);
    chk("t6_unlock", bus.unlock, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    try_code(16'h1234);
    chk("t6_default_pwd", bus.state, 2'b10);

    // 4: short entry is wrong; fifth digit dropped
    do_reset();
    press(4'h1); press(4'h2); press(4'hA);
    chk("t4_short_err", bus.err_cnt, 2'd1);
    chk("t4_short_st", bus.state, 2'b00);
    press(4'h5); press(4'h6); press(4'h7); press(4'h8); press(4'h9);
    chk("t4_entry", bus.entry, 16'h5678);
    chk("t4_dcnt", bus.digit_cnt, 3'd4);

    // 5: key and timeout pulse together in ALARM; timeout ignored in OPEN
    do_reset();
    try_code(16'h0000); try_code(16'h0000); try_code(16'h0000);
    chk("t5_alarm", bus.state, 2'b11);
    @(negedge clk);
    bus.timeout = 1'b1;
    @(posedge clk);
    @(posedge clk); #1;
    bus.key_valid = 1'b1;
    bus.key_code  = 4'h5;
    @(posedge clk); #1;
    bus.key_valid = 1'b0;
    bus.key_code  = 4'hF;
    chk("t5_sim_state", bus.state, 2'b00);
    chk("t5_sim_entry", bus.entry, 16'h0);
    chk("t5_sim_dcnt", bus.digit_cnt, 3'd0);
    repeat (3) @(negedge clk);
    bus.timeout = 1'b0;
    repeat (4) @(negedge clk);
    try_code(16'h1234);
    chk("t5_open", bus.state, 2'b10);
    bus.timeout = 1'b1;
    repeat (6) @(negedge clk);
    chk("t5_to_open_st", bus.state, 2'b10);
    chk("t5_to_open_ul", bus.unlock, 1'b1);
    bus.timeout = 1'b0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
